// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared ASCII constants and streaming FSM state encoding
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_TERM_CR = 2'd2,
        ST_TERM_LF = 2'd3
    } state_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational hex nibble to ASCII digit converter
module nibble_to_ascii
    import ascii_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    logic [7:0] alpha_base;

    always_comb begin
        alpha_base = UPPERCASE ? ASCII_UPPER_A : ASCII_LOWER_A;
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = alpha_base + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/value_to_ascii_stream.sv
// rtl/value_to_ascii_stream.sv - streams a latched value as hex ASCII bytes, MSD first, optional CR/LF
module value_to_ascii_stream
    import ascii_pkg::*;
#(
    parameter int NIBBLES   = 8,
    parameter bit UPPERCASE = 1'b1,
    parameter bit TERM_CRLF = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4*NIBBLES-1:0] value_in,
    input  logic                 start,
    input  logic                 suppress_zeros,
    output logic [7:0]           char_out,
    output logic                 char_valid,
    input  logic                 char_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int VW   = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [VW-1:0]     value_q, value_d;
    logic [7:0]        char_q, char_d;
    logic              done_q, done_d;

    logic [IDXW-1:0]   lead_idx;
    logic [IDXW-1:0]   start_idx;
    logic [IDXW-1:0]   next_idx;
    logic [3:0]        conv_nib;
    logic [7:0]        conv_char;
    logic              xfer;

    // Highest nonzero nibble wins; an all-zero value falls back to index 0.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (value_in[4*i +: 4] != 4'h0) begin
                lead_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        start_idx = suppress_zeros ? lead_idx : IDXW'(NIBBLES - 1);
        next_idx  = (idx_q == '0) ? '0 : idx_q - IDXW'(1);
        // One converter serves both the first digit (from value_in) and each following digit.
        if (state_q == ST_IDLE) begin
            conv_nib = 4'(value_in >> {start_idx, 2'b00});
        end else begin
            conv_nib = 4'(value_q >> {next_idx, 2'b00});
        end
    end

    nibble_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_nibble_to_ascii (
        .nibble (conv_nib),
        .ascii  (conv_char)
    );

    assign char_valid = (state_q != ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign char_out   = char_q;
    assign done       = done_q;
    assign xfer       = char_valid & char_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        value_d = value_q;
        char_d  = char_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    value_d = value_in;
                    idx_d   = start_idx;
                    char_d  = conv_char;
                    state_d = ST_DIGITS;
                end
            end
            ST_DIGITS: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        if (TERM_CRLF) begin
                            state_d = ST_TERM_CR;
                            char_d  = ASCII_CR;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d  = next_idx;
                        char_d = conv_char;
                    end
                end
            end
            ST_TERM_CR: begin
                if (xfer) begin
                    state_d = ST_TERM_LF;
                    char_d  = ASCII_LF;
                end
            end
            ST_TERM_LF: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            value_q <= '0;
            char_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            char_q  <= char_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_value_to_ascii_stream.sv
// tb/tb_value_to_ascii_stream.sv - directed self-checking bench for value_to_ascii_stream
module tb_value_to_ascii_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] value_a = '0;
    logic        start_a = 1'b0;
    logic        sz_a = 1'b0;
    logic [7:0]  char_a;
    logic        valid_a;
    logic        ready_a = 1'b1;
    logic        busy_a;
    logic        done_a;

    logic [15:0] value_b = '0;
    logic        start_b = 1'b0;
    logic        sz_b = 1'b0;
    logic [7:0]  char_b;
    logic        valid_b;
    logic        ready_b = 1'b1;
    logic        busy_b;
    logic        done_b;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    value_to_ascii_stream #(.NIBBLES(8), .UPPERCASE(1'b1), .TERM_CRLF(1'b1)) dut_a (
        .clk (clk), .reset (reset), .value_in (value_a), .start (start_a),
        .suppress_zeros (sz_a), .char_out (char_a), .char_valid (valid_a),
        .char_ready (ready_a), .busy (busy_a), .done (done_a)
    );

    value_to_ascii_stream #(.NIBBLES(4), .UPPERCASE(1'b0), .TERM_CRLF(1'b0)) dut_b (
        .clk (clk), .reset (reset), .value_in (value_b), .start (start_b),
        .suppress_zeros (sz_b), .char_out (char_b), .char_valid (valid_b),
        .char_ready (ready_b), .busy (busy_b), .done (done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks {busy, valid, char} for one presented byte, then advances a cycle.
    task automatic byte_chk(input string tag, input bit sel_b, input logic [7:0] e);
        if (sel_b) chk(tag, {22'h0, busy_b, valid_b, char_b}, {22'h0, 2'b11, e});
        else       chk(tag, {22'h0, busy_a, valid_a, char_a}, {22'h0, 2'b11, e});
        step();
    endtask

    task automatic done_chk(input string tag, input bit sel_b);
        if (sel_b) chk({tag, "_done"}, {29'h0, done_b, busy_b, valid_b}, {29'h0, 3'b100});
        else       chk({tag, "_done"}, {29'h0, done_a, busy_a, valid_a}, {29'h0, 3'b100});
    endtask

    task automatic start_chk_a(input logic [31:0] v, input logic sz);
        value_a = v;
        sz_a    = sz;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        chk("reset_a", {22'h0, done_a, busy_a, valid_a, 1'b0, char_a}, 32'h0);
        chk("reset_b", {22'h0, done_b, busy_b, valid_b, 1'b0, char_b}, 32'h0);
        reset = 1'b0;
        step();

        // 1: full-width uppercase with terminator
        start_chk_a(32'hDEADBEEF, 1'b0);
        byte_chk("t1_b0", 0, 8'h44); byte_chk("t1_b1", 0, 8'h45);
        byte_chk("t1_b2", 0, 8'h41); byte_chk("t1_b3", 0, 8'h44);
        byte_chk("t1_b4", 0, 8'h42); byte_chk("t1_b5", 0, 8'h45);
        byte_chk("t1_b6", 0, 8'h45); byte_chk("t1_b7", 0, 8'h46);
        byte_chk("t1_cr", 0, 8'h0D); byte_chk("t1_lf", 0, 8'h0A);
        done_chk("t1", 0);
        chk("t1_char_hold", {24'h0, char_a}, 32'h0A);
        step();
        chk("t1_done_once", {30'h0, done_a, busy_a}, 32'h0);

        // 2: leading-zero suppression
        start_chk_a(32'h000000A5, 1'b1);
        byte_chk("t2a_b0", 0, 8'h41); byte_chk("t2a_b1", 0, 8'h35);
        byte_chk("t2a_cr", 0, 8'h0D); byte_chk("t2a_lf", 0, 8'h0A);
        done_chk("t2a", 0);
        step();
        start_chk_a(32'h00000000, 1'b1);
        byte_chk("t2b_b0", 0, 8'h30);
        byte_chk("t2b_cr", 0, 8'h0D); byte_chk("t2b_lf", 0, 8'h0A);
        done_chk("t2b", 0);
        step();

        // 3: backpressure holds '2' for three cycles
        start_chk_a(32'h12345678, 1'b0);
        byte_chk("t3_b0", 0, 8'h31);
        ready_a = 1'b0;
        byte_chk("t3_hold0", 0, 8'h32);
        byte_chk("t3_hold1", 0, 8'h32);
        byte_chk("t3_hold2", 0, 8'h32);
        ready_a = 1'b1;
        byte_chk("t3_b1", 0, 8'h32); byte_chk("t3_b2", 0, 8'h33);
        byte_chk("t3_b3", 0, 8'h34); byte_chk("t3_b4", 0, 8'h35);
        byte_chk("t3_b5", 0, 8'h36); byte_chk("t3_b6", 0, 8'h37);
        byte_chk("t3_b7", 0, 8'h38);
        byte_chk("t3_cr", 0, 8'h0D); byte_chk("t3_lf", 0, 8'h0A);
        done_chk("t3", 0);
        step();

        // 4: start while busy is ignored; start in done cycle chains a new string
        start_chk_a(32'h89ABCDEF, 1'b0);
        byte_chk("t4_b0", 0, 8'h38);
        value_a = 32'h11111111;
        start_a = 1'b1;
        byte_chk("t4_b1", 0, 8'h39);
        start_a = 1'b0;
        byte_chk("t4_b2", 0, 8'h41); byte_chk("t4_b3", 0, 8'h42);
        byte_chk("t4_b4", 0, 8'h43); byte_chk("t4_b5", 0, 8'h44);
        byte_chk("t4_b6", 0, 8'h45); byte_chk("t4_b7", 0, 8'h46);
        byte_chk("t4_cr", 0, 8'h0D); byte_chk("t4_lf", 0, 8'h0A);
        done_chk("t4", 0);
        start_chk_a(32'h000000FF, 1'b0);
        byte_chk("t4n_b0", 0, 8'h30); byte_chk("t4n_b1", 0, 8'h30);
        byte_chk("t4n_b2", 0, 8'h30); byte_chk("t4n_b3", 0, 8'h30);
        byte_chk("t4n_b4", 0, 8'h30); byte_chk("t4n_b5", 0, 8'h30);
        byte_chk("t4n_b6", 0, 8'h46); byte_chk("t4n_b7", 0, 8'h46);
        byte_chk("t4n_cr", 0, 8'h0D); byte_chk("t4n_lf", 0, 8'h0A);
        done_chk("t4n", 0);
        step();

        // 5: reset mid-stream aborts with no done pulse
        start_chk_a(32'h12345678, 1'b0);
        byte_chk("t5_b0", 0, 8'h31); byte_chk("t5_b1", 0, 8'h32);
        byte_chk("t5_b2", 0, 8'h33);
        reset = 1'b1;
        step();
        chk("t5_abort", {22'h0, done_a, busy_a, valid_a, 1'b0, char_a}, 32'h0);
        reset = 1'b0;
        step();
        chk("t5_no_done", {29'h0, done_a, busy_a, valid_a}, 32'h0);
        start_chk_a(32'h00000C01, 1'b1);
        byte_chk("t5n_b0", 0, 8'h43); byte_chk("t5n_b1", 0, 8'h30);
        byte_chk("t5n_b2", 0, 8'h31);
        byte_chk("t5n_cr", 0, 8'h0D); byte_chk("t5n_lf", 0, 8'h0A);
        done_chk("t5n", 0);
        step();

        // 6: 4-digit lowercase, no terminator
        value_b = 16'hFA0C;
        sz_b    = 1'b0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        byte_chk("t6_b0", 1, 8'h66); byte_chk("t6_b1", 1, 8'h61);
        byte_chk("t6_b2", 1, 8'h30); byte_chk("t6_b3", 1, 8'h63);
        done_chk("t6", 1);
        step();
        chk("t6_done_once", {30'h0, done_b, busy_b}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
